// File: rtl/unidade_mult_div.sv
// Iterative unsigned multiply/divide unit: radix-2 shift-add multiply and
// restoring division, one bit per cycle, with a start/busy/done handshake.
module unidade_mult_div #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iniciar,
  input  logic [1:0]            operacao,
  input  logic [DATA_WIDTH-1:0] operando_a,
  input  logic [DATA_WIDTH-1:0] operando_b,
  output logic                  ocupado,
  output logic                  pronto,
  output logic [DATA_WIDTH-1:0] resultado,
  output logic                  div_por_zero
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {OCIOSO, CALCULA, FIM} estado_t;

  estado_t estado, proximo;

  logic [DATA_WIDTH-1:0]   a_reg, b_reg;
  logic [1:0]              op_reg;
  logic [2*DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH:0]     resto;
  logic [CNT_W-1:0]        contador;

  logic                    b_zero, ultimo, a_bit, b_bit, q_bit;
  logic [DATA_WIDTH-1:0]   mascara_a, mascara_b, selecionado;
  logic [2*DATA_WIDTH-1:0] parcela, acc_mul;
  logic [DATA_WIDTH:0]     deslocado, diferenca;

  assign b_zero = (operando_b == '0);
  // CALCULA lasts DATA_WIDTH+1 cycles: DATA_WIDTH iterations plus one cycle
  // where the settled registers are selected into resultado.
  assign ultimo = (contador == CNT_W'(DATA_WIDTH));

  always_ff @(posedge clk) begin
    if (!rst_n) estado <= OCIOSO;
    else        estado <= proximo;
  end

  always_comb begin
    proximo = estado;
    case (estado)
      OCIOSO:  if (iniciar) proximo = (operacao[1] && b_zero) ? FIM : CALCULA;
      CALCULA: if (ultimo) proximo = FIM;
      FIM:     proximo = OCIOSO;
      default: proximo = OCIOSO;
    endcase
  end

  always_comb begin
    ocupado = (estado != OCIOSO);
    pronto  = (estado == FIM);
  end

  always_comb begin
    mascara_b = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << contador;
    mascara_a = {1'b1, {(DATA_WIDTH-1){1'b0}}} >> contador;
    b_bit     = |(b_reg & mascara_b);
    a_bit     = |(a_reg & mascara_a);
    parcela   = b_bit ? ({{DATA_WIDTH{1'b0}}, a_reg} << contador) : '0;
    acc_mul   = acc + parcela;
    deslocado = {resto[DATA_WIDTH-1:0], a_bit};
    diferenca = deslocado - {1'b0, b_reg};
    // A set top bit means the shifted remainder already exceeds any divisor.
    q_bit     = resto[DATA_WIDTH] || (deslocado >= {1'b0, b_reg});
    case (op_reg)
      2'b00:   selecionado = acc[DATA_WIDTH-1:0];
      2'b01:   selecionado = acc[2*DATA_WIDTH-1:DATA_WIDTH];
      2'b10:   selecionado = acc[DATA_WIDTH-1:0];
      default: selecionado = resto[DATA_WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg        <= '0;
      b_reg        <= '0;
      op_reg       <= '0;
      acc          <= '0;
      resto        <= '0;
      contador     <= '0;
      resultado    <= '0;
      div_por_zero <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: if (iniciar) begin
          a_reg    <= operando_a;
          b_reg    <= operando_b;
          op_reg   <= operacao;
          acc      <= '0;
          resto    <= '0;
          contador <= '0;
          if (operacao[1] && b_zero) begin
            resultado    <= operacao[0] ? operando_a : '1;
            div_por_zero <= 1'b1;
          end else begin
            div_por_zero <= 1'b0;
          end
        end
        CALCULA: if (ultimo) begin
          resultado <= selecionado;
        end else begin
          contador <= contador + 1'b1;
          if (!op_reg[1]) begin
            acc <= acc_mul;
          end else begin
            resto <= q_bit ? diferenca : deslocado;
            acc   <= {acc[2*DATA_WIDTH-2:0], q_bit};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_mult_div.sv
// Self-checking bench for unidade_mult_div: vector table, randomized ops
// against an arithmetic reference model, and handshake corner sequences.
module tb_unidade_mult_div;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         iniciar = 1'b0;
  logic [1:0]   operacao = '0;
  logic [W-1:0] operando_a = '0;
  logic [W-1:0] operando_b = '0;
  logic         ocupado, pronto, div_por_zero;
  logic [W-1:0] resultado;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_dz;
    int          exp_lat;
  } vetor_t;

  vetor_t tabela[$];

  unidade_mult_div #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .iniciar(iniciar), .operacao(operacao),
    .operando_a(operando_a), .operando_b(operando_b), .ocupado(ocupado),
    .pronto(pronto), .resultado(resultado), .div_por_zero(div_por_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] refResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Starts one operation from idle, scrambles the inputs right after the
  // accepting edge, and reports latency, busy cycles, result and flag.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               output int lat, output int busy, output logic [31:0] res, output logic dz);
    lat = 0; busy = 0; res = '0; dz = 1'b0;
    @(negedge clk);
    operacao = op; operando_a = a; operando_b = b; iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0; operacao = ~op; operando_a = ~a; operando_b = b + 32'd3;
    for (int n = 1; n <= 100; n++) begin
      if (ocupado) busy++;
      if (pronto) begin
        lat = n; res = resultado; dz = div_por_zero;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    checkOutput("pronto_single_pulse", {31'b0, pronto}, 32'd0);
  endtask

  initial begin
    int lat, busy, npronto, t_pronto, last_t;
    logic [31:0] res, res_pronto;
    logic dz;

    tabela.push_back('{2'b00, 32'd7,          32'd6,          32'd42,         1'b0, 34});
    tabela.push_back('{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b0, 34});
    tabela.push_back('{2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  1'b0, 34});
    tabela.push_back('{2'b10, 32'd100,        32'd7,          32'd14,         1'b0, 34});
    tabela.push_back('{2'b11, 32'd100,        32'd7,          32'd2,          1'b0, 34});
    tabela.push_back('{2'b10, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  1'b1, 1});
    tabela.push_back('{2'b11, 32'h1234_5678,  32'd0,          32'h1234_5678,  1'b1, 1});
    tabela.push_back('{2'b01, 32'h0001_0000,  32'h0001_0000,  32'h0000_0001,  1'b0, 34});
    tabela.push_back('{2'b10, 32'hDEAD_BEEF,  32'd1,          32'hDEAD_BEEF,  1'b0, 34});
    tabela.push_back('{2'b11, 32'd7,          32'd7,          32'd0,          1'b0, 34});
    tabela.push_back('{2'b10, 32'd3,          32'd10,         32'd0,          1'b0, 34});
    tabela.push_back('{2'b11, 32'd3,          32'd10,         32'd3,          1'b0, 34});
    tabela.push_back('{2'b01, 32'd0,          32'hFFFF_FFFF,  32'd0,          1'b0, 34});
    tabela.push_back('{2'b10, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          1'b0, 34});

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ocupado", {31'b0, ocupado}, 32'd0);
    checkOutput("reset_pronto", {31'b0, pronto}, 32'd0);
    checkOutput("reset_resultado", resultado, 32'd0);
    checkOutput("reset_dz", {31'b0, div_por_zero}, 32'd0);
    rst_n = 1'b1;

    foreach (tabela[i]) begin
      applyStimulus(tabela[i].op, tabela[i].a, tabela[i].b, lat, busy, res, dz);
      checkOutput($sformatf("vec%0d_res", i), res, tabela[i].exp_res);
      checkOutput($sformatf("vec%0d_dz", i), {31'b0, dz}, {31'b0, tabela[i].exp_dz});
      checkOutput($sformatf("vec%0d_lat", i), lat, tabela[i].exp_lat);
      checkOutput($sformatf("vec%0d_busy", i), busy, tabela[i].exp_lat);
    end

    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      logic [31:0] a, b;
      int sel;
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      sel = $urandom_range(0, 9);
      b = (sel == 0) ? 32'd0 : (sel < 4) ? 32'($urandom_range(1, 15)) : $urandom;
      applyStimulus(op, a, b, lat, busy, res, dz);
      checkOutput($sformatf("rnd%0d_res op=%0d a=%h b=%h", i, op, a, b), res, refResult(op, a, b));
      checkOutput($sformatf("rnd%0d_dz", i), {31'b0, dz}, {31'b0, (op[1] && b == 0)});
      checkOutput($sformatf("rnd%0d_lat", i), lat, (op[1] && b == 0) ? 1 : 34);
    end

    // Reset in the middle of a multiply aborts it without a pronto.
    @(negedge clk);
    operacao = 2'b00; operando_a = 32'd7; operando_b = 32'd6; iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midreset_ocupado", {31'b0, ocupado}, 32'd0);
    checkOutput("midreset_resultado", resultado, 32'd0);
    npronto = 0;
    for (int n = 0; n < 40; n++) begin
      if (pronto) npronto++;
      @(negedge clk);
    end
    checkOutput("midreset_no_pronto", npronto, 0);
    applyStimulus(2'b00, 32'd7, 32'd6, lat, busy, res, dz);
    checkOutput("after_reset_res", res, 32'd42);
    checkOutput("after_reset_lat", lat, 34);

    // A start request while busy is neither accepted nor queued.
    @(negedge clk);
    operacao = 2'b10; operando_a = 32'd50; operando_b = 32'd5; iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
    npronto = 0; t_pronto = 0; res_pronto = '0;
    for (int c = 1; c <= 80; c++) begin
      if (c == 5) begin
        operacao = 2'b00; operando_a = 32'd3; operando_b = 32'd3; iniciar = 1'b1;
      end else if (c == 6) begin
        iniciar = 1'b0;
      end
      if (pronto) begin
        npronto++;
        if (npronto == 1) begin t_pronto = c; res_pronto = resultado; end
      end
      @(negedge clk);
    end
    checkOutput("busy_pronto_count", npronto, 1);
    checkOutput("busy_res", res_pronto, 32'd10);
    checkOutput("busy_lat", t_pronto, 34);

    // Back-to-back with iniciar held high; operands disturbed mid-CALCULA.
    @(negedge clk);
    operacao = 2'b10; operando_a = 32'd9; operando_b = 32'd2; iniciar = 1'b1;
    @(negedge clk);
    npronto = 0; last_t = 0;
    for (int c = 1; c <= 150; c++) begin
      if (c == 5) begin
        operacao = 2'b00; operando_a = 32'd100; operando_b = 32'd3;
      end else if (c == 20) begin
        operacao = 2'b10; operando_a = 32'd9; operando_b = 32'd2;
      end
      if (pronto) begin
        npronto++;
        checkOutput($sformatf("b2b%0d_res", npronto), resultado, 32'd4);
        checkOutput($sformatf("b2b%0d_time", npronto), c - last_t, (npronto == 1) ? 34 : 35);
        last_t = c;
        if (npronto == 3) begin
          iniciar = 1'b0;
          break;
        end
      end
      @(negedge clk);
    end
    iniciar = 1'b0;
    checkOutput("b2b_count", npronto, 3);
    repeat (3) @(negedge clk);
    checkOutput("b2b_idle", {31'b0, ocupado}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
